// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// register offsets, FSM state enums and the offset-to-register decode.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam logic [3:0] OFF_REG0 = 4'h0;
  localparam logic [3:0] OFF_REG1 = 4'h4;
  localparam logic [3:0] OFF_SUM  = 4'h8;
  localparam logic [3:0] OFF_CNT  = 4'hC;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  typedef enum logic [2:0] {
    SEL_REG0, SEL_REG1, SEL_SUM, SEL_CNT, SEL_NONE
  } reg_sel_e;

  typedef struct packed {
    wstate_e wstate;
    rstate_e rstate;
  } axil_dbg_t;

  // Byte-lane bits [1:0] are ignored; anything at or above offset 0x10 is unmapped.
  function automatic reg_sel_e sel_from_offset(input logic [3:0] low, input logic in_range);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (in_range) begin
      case ({low[3:2], 2'b00})
        OFF_REG0: sel = SEL_REG0;
        OFF_REG1: sel = SEL_REG1;
        OFF_SUM:  sel = SEL_SUM;
        OFF_CNT:  sel = SEL_CNT;
        default:  sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/axil_reg_slave_wcap.sv
// Independent capture of the AW and W channels: each is accepted once and held
// until the write FSM consumes the pair.
module axil_reg_slave_wcap #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic                    idle_next_i,
  input  logic                    clear_i,
  output logic                    aw_held_o,
  output logic                    w_held_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o
);

  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic                    awready_q, wready_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;

  logic aw_hs, w_hs;
  assign aw_hs = awvalid_i && awready_q;
  assign w_hs  = wvalid_i && wready_q;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    if (clear_i) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs) aw_held_d = 1'b1;
      if (w_hs)  w_held_d  = 1'b1;
    end
  end

  // Readies are registered so they are low during reset and rise on the first released edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= idle_next_i && !aw_held_d;
      wready_q  <= idle_next_i && !w_held_d;
      if (aw_hs) awaddr_q <= awaddr_i;
      if (w_hs) begin
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign aw_held_o = aw_held_q;
  assign w_held_o  = w_held_q;
  assign awaddr_o  = awaddr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave with two RW registers, their registered sum and an optional
// OKAY-write counter enabled by AXIL_REG_SLAVE_CNT_EN.
// Every channel uses valid/ready: a beat transfers on a rising edge where both are 1,
// and a source holds valid and payload stable until that edge.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  output axil_dbg_t               dbg_state_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE;
    return sel_from_offset(off[3:0], (off >> 4) == '0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  logic                  aw_held, w_held, both_held;
  logic [ADDR_WIDTH-1:0] h_awaddr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [STRB_WIDTH-1:0] h_wstrb;
  logic                  w_idle_next, do_write;

  wstate_e               wstate_q;
  logic                  bvalid_q;
  logic [RESP_WIDTH-1:0] bresp_q;

  assign both_held = aw_held && w_held;
  assign do_write  = (wstate_q == W_IDLE) && both_held;
  assign w_idle_next = (wstate_q == W_IDLE) ? !both_held : s0_axi_bready;

  axil_reg_slave_wcap #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wcap (
    .clk_i      (s0_axi_aclk),
    .rst_ni     (s0_axi_aresetn),
    .awaddr_i   (s0_axi_awaddr),
    .awvalid_i  (s0_axi_awvalid),
    .awready_o  (s0_axi_awready),
    .wdata_i    (s0_axi_wdata),
    .wstrb_i    (s0_axi_wstrb),
    .wvalid_i   (s0_axi_wvalid),
    .wready_o   (s0_axi_wready),
    .idle_next_i(w_idle_next),
    .clear_i    (do_write),
    .aw_held_o  (aw_held),
    .w_held_o   (w_held),
    .awaddr_o   (h_awaddr),
    .wdata_o    (h_wdata),
    .wstrb_o    (h_wstrb)
  );

  reg_sel_e   wr_sel;
  logic       wr_ok;
  logic [1:0] wr_resp;
  assign wr_sel  = decode(h_awaddr);
  assign wr_ok   = (wr_sel == SEL_REG0) || (wr_sel == SEL_REG1);
  assign wr_resp = wr_ok ? RESP_OKAY : RESP_SLVERR;

  logic [DATA_WIDTH-1:0] reg0_q, reg0_d, reg1_q, reg1_d, sum_q, cnt_val;

  always_comb begin
    reg0_d = reg0_q;
    reg1_d = reg1_q;
    if (do_write && wr_sel == SEL_REG0) reg0_d = merge_bytes(reg0_q, h_wdata, h_wstrb);
    if (do_write && wr_sel == SEL_REG1) reg1_d = merge_bytes(reg1_q, h_wdata, h_wstrb);
  end

  // SUM is built from the current register values, so it trails a write by one cycle.
  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) begin
      reg0_q <= '0;
      reg1_q <= '0;
      sum_q  <= '0;
    end else begin
      reg0_q <= reg0_d;
      reg1_q <= reg1_d;
      sum_q  <= reg0_q + reg1_q;
    end
  end

`ifdef AXIL_REG_SLAVE_CNT_EN
  logic [DATA_WIDTH-1:0] cnt_q;
  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) cnt_q <= '0;
    else if (do_write && wr_ok) cnt_q <= cnt_q + DATA_WIDTH'(1);
  end
  assign cnt_val = cnt_q;
`else
  assign cnt_val = '0;
`endif

  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) begin
      wstate_q <= W_IDLE;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: if (both_held) begin
          wstate_q <= W_RESP;
          bvalid_q <= 1'b1;
          bresp_q  <= RESP_WIDTH'(wr_resp);
        end
        W_RESP: if (s0_axi_bready) begin
          wstate_q <= W_IDLE;
          bvalid_q <= 1'b0;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  reg_sel_e              rd_sel;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [1:0]            rd_resp;

  always_comb begin
    rd_sel  = decode(s0_axi_araddr);
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      SEL_REG0: rd_val = reg0_q;
      SEL_REG1: rd_val = reg1_q;
      SEL_SUM:  rd_val = sum_q;
      SEL_CNT:  rd_val = cnt_val;
      default:  rd_resp = RESP_SLVERR;
    endcase
  end

  rstate_e               rstate_q;
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [RESP_WIDTH-1:0] rresp_q;

  // Read data is sampled from pre-edge register values, so a same-edge write is not visible.
  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s0_axi_arvalid) begin
            rstate_q  <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_val;
            rresp_q   <= RESP_WIDTH'(rd_resp);
          end
        end
        R_DATA: if (s0_axi_rready) begin
          rstate_q  <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s0_axi_bvalid      = bvalid_q;
  assign s0_axi_bresp       = bresp_q;
  assign s0_axi_arready     = arready_q;
  assign s0_axi_rvalid      = rvalid_q;
  assign s0_axi_rdata       = rdata_q;
  assign s0_axi_rresp       = rresp_q;
  assign dbg_state_o.wstate = wstate_q;
  assign dbg_state_o.rstate = rstate_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed scenarios plus randomized
// transactions scored against a register-level model.
module tb_axil_reg_slave;
  import axil_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int RW  = 3;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0, awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0, wready;
  logic [RW-1:0] bresp;
  logic          bvalid, bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0, arready;
  logic [DW-1:0] rdata;
  logic [RW-1:0] rresp;
  logic          rvalid, rready = 1'b0;
  axil_dbg_t     dbg;

  axil_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .BASE_ADDR(0)) dut (
    .s0_axi_aclk(clk), .s0_axi_aresetn(aresetn),
    .s0_axi_awaddr(awaddr), .s0_axi_awvalid(awvalid), .s0_axi_awready(awready),
    .s0_axi_wdata(wdata), .s0_axi_wstrb(wstrb), .s0_axi_wvalid(wvalid), .s0_axi_wready(wready),
    .s0_axi_bresp(bresp), .s0_axi_bvalid(bvalid), .s0_axi_bready(bready),
    .s0_axi_araddr(araddr), .s0_axi_arvalid(arvalid), .s0_axi_arready(arready),
    .s0_axi_rdata(rdata), .s0_axi_rresp(rresp), .s0_axi_rvalid(rvalid), .s0_axi_rready(rready),
    .dbg_state_o(dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // scoreboard expected queues
  logic [RW-1:0] exp_bresp_q[$];
  logic [DW-1:0] exp_rdata_q[$];
  logic [RW-1:0] exp_rresp_q[$];

  // behavioural register model
  logic [DW-1:0] m_reg0 = '0, m_reg1 = '0, m_cnt = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout after %0d cycles, expected handshake", name, TMO);
  endtask

  function automatic int m_index(input logic [AW-1:0] addr);
    int off;
    off = int'(addr);
    if (off >= 16) return -1;
    return off / 4;
  endfunction

  function automatic logic [DW-1:0] m_rdata(input logic [AW-1:0] addr);
    case (m_index(addr))
      0: return m_reg0;
      1: return m_reg1;
      2: return m_reg0 + m_reg1;
`ifdef AXIL_REG_SLAVE_CNT_EN
      3: return m_cnt;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic logic [RW-1:0] m_rresp(input logic [AW-1:0] addr);
    return (m_index(addr) < 0) ? RW'(2) : RW'(0);
  endfunction

  function automatic logic [RW-1:0] m_bresp(input logic [AW-1:0] addr);
    return (m_index(addr) == 0 || m_index(addr) == 1) ? RW'(0) : RW'(2);
  endfunction

  task automatic m_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
    logic [DW-1:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (m_index(addr) == 0) m_reg0 = (m_reg0 & ~mask) | (data & mask);
    if (m_index(addr) == 1) m_reg1 = (m_reg1 & ~mask) | (data & mask);
    if (m_bresp(addr) == RW'(0)) m_cnt = m_cnt + 1;
  endtask

  // compare process: every cycle a response is valid it must match the queue head
  always @(negedge clk) begin
    if (chk_en) begin
      if (bvalid) begin
        check("aw_w_ready_in_resp", {30'd0, awready, wready}, '0);
        if (exp_bresp_q.size() == 0) check("b_unexpected", 1, 0);
        else begin
          check("bresp", DW'(bresp), DW'(exp_bresp_q[0]));
          if (bready) void'(exp_bresp_q.pop_front());
        end
      end
      if (rvalid) begin
        if (exp_rdata_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          check("rdata", rdata, exp_rdata_q[0]);
          check("rresp", DW'(rresp), DW'(exp_rresp_q[0]));
          if (rready) begin
            void'(exp_rdata_q.pop_front());
            void'(exp_rresp_q.pop_front());
          end
        end
      end
      check("arready_vs_rvalid", DW'(arready), DW'(!rvalid));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_aw(input logic [AW-1:0] addr, input int dly);
    int n;
    repeat (dly) step();
    awaddr = addr;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < TMO) begin step(); n++; end
    if (n >= TMO) timeout("aw_handshake");
    step();
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [DW-1:0] data, input logic [3:0] strb, input int dly);
    int n;
    repeat (dly) step();
    wdata = data;
    wstrb = strb;
    wvalid = 1'b1;
    n = 0;
    while (!wready && n < TMO) begin step(); n++; end
    if (n >= TMO) timeout("w_handshake");
    step();
    wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int lat;
    exp_bresp_q.push_back(m_bresp(addr));
    fork
      drive_aw(addr, aw_dly);
      drive_w(data, strb, w_dly);
    join
    lat = 0;
    while (!bvalid && lat < TMO) begin step(); lat++; end
    if (lat >= TMO) timeout("bvalid");
    else check("b_latency", DW'(lat), DW'(1));
    repeat (b_dly) step();
    bready = 1'b1;
    step();
    bready = 1'b0;
    m_write(addr, data, strb);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int ar_dly, input int rr_dly,
                         output logic [DW-1:0] got_data, output logic [RW-1:0] got_resp);
    int n;
    exp_rdata_q.push_back(m_rdata(addr));
    exp_rresp_q.push_back(m_rresp(addr));
    repeat (ar_dly) step();
    araddr = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < TMO) begin step(); n++; end
    if (n >= TMO) timeout("ar_handshake");
    step();
    arvalid = 1'b0;
    check("r_latency", DW'(rvalid), DW'(1));
    got_data = rdata;
    got_resp = rresp;
    repeat (rr_dly) step();
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    aresetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (2) step();
    check("rst_awready", DW'(awready), '0);
    check("rst_wready", DW'(wready), '0);
    check("rst_arready", DW'(arready), '0);
    check("rst_bvalid", DW'(bvalid), '0);
    check("rst_rvalid", DW'(rvalid), '0);
    check("rst_bresp", DW'(bresp), '0);
    check("rst_rresp", DW'(rresp), '0);
    check("rst_rdata", rdata, '0);
    aresetn = 1'b1;
    step();
    check("rel_awready", DW'(awready), DW'(1));
    check("rel_wready", DW'(wready), DW'(1));
    check("rel_arready", DW'(arready), DW'(1));
    exp_bresp_q.delete();
    exp_rdata_q.delete();
    exp_rresp_q.delete();
    m_reg0 = '0; m_reg1 = '0; m_cnt = '0;
    chk_en = 1'b1;
  endtask

  logic [DW-1:0] got_d, old_v;
  logic [RW-1:0] got_r;
  logic [AW-1:0] addr_tab[9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h40, 8'hFC, 8'h01, 8'h06};

  initial begin
    do_reset();

    // full-word write with AW and W together, then read back
    do_write(8'h00, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(8'h00, 0, 0, got_d, got_r);
    check("lit_reg0", got_d, 32'h12345678);

    // W ahead of AW by 3 cycles, partial strobes into REG1
    do_write(8'h04, 32'hAABBCCDD, 4'h5, 3, 0, 0);
    do_read(8'h04, 0, 1, got_d, got_r);
    check("lit_reg1_strb", got_d, 32'h00BB00DD);

    // SUM wrap and unmapped read
    do_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 2, 0);
    do_write(8'h04, 32'h00000002, 4'hF, 1, 0, 0);
    do_read(8'h08, 0, 0, got_d, got_r);
    check("lit_sum_wrap", got_d, 32'h00000001);
    do_read(8'h10, 0, 0, got_d, got_r);
    check("lit_unmapped_data", got_d, '0);
    check("lit_unmapped_resp", DW'(got_r), DW'(2));

    // write to RO SUM with bready held off; compare process checks stability each cycle
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0, 5);
    do_read(8'h08, 0, 0, got_d, got_r);
    check("lit_sum_unchanged", got_d, 32'h00000001);

    // counter: three OKAY writes and one SLVERR write from reset
    do_reset();
    do_write(8'h00, 32'h11111111, 4'hF, 0, 0, 0);
    do_write(8'h04, 32'h22222222, 4'h3, 0, 1, 0);
    do_write(8'h00, 32'h33333333, 4'h0, 2, 0, 0);
    do_write(8'h0C, 32'h44444444, 4'hF, 0, 0, 0);
    do_read(8'h0C, 0, 0, got_d, got_r);
`ifdef AXIL_REG_SLAVE_CNT_EN
    check("lit_cnt", got_d, 32'd3);
`else
    check("lit_cnt", got_d, 32'd0);
`endif
    check("lit_cnt_resp", DW'(got_r), DW'(0));

    // read and write to REG0 completing on the same edge returns the old value
    old_v = m_reg0;
    fork
      do_write(8'h00, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      begin
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        do_read(8'h00, 1, 0, d, r);
        check("same_edge_old_value", d, old_v);
      end
    join
    do_read(8'h00, 0, 0, got_d, got_r);
    check("lit_reg0_after_race", got_d, 32'hCAFEF00D);

    // randomized sequential traffic
    for (int i = 0; i < 150; i++) begin
      logic [AW-1:0] a;
      a = addr_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 3), got_d, got_r);
    end

    // reset while a read response is pending
    do_write(8'h00, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
    chk_en = 1'b0;
    araddr = 8'h00;
    arvalid = 1'b1;
    begin
      int n;
      n = 0;
      while (!arready && n < TMO) begin step(); n++; end
      if (n >= TMO) timeout("ar_before_reset");
    end
    step();
    arvalid = 1'b0;
    check("pre_reset_rvalid", DW'(rvalid), DW'(1));
    aresetn = 1'b0;
    step();
    check("reset_drops_rvalid", DW'(rvalid), '0);
    check("reset_drops_arready", DW'(arready), '0);
    step();
    aresetn = 1'b1;
    step();
    check("arready_after_release", DW'(arready), DW'(1));
    exp_bresp_q.delete();
    exp_rdata_q.delete();
    exp_rresp_q.delete();
    m_reg0 = '0; m_reg1 = '0; m_cnt = '0;
    chk_en = 1'b1;
    do_read(8'h00, 0, 0, got_d, got_r);
    check("post_reset_reg0", got_d, '0);
    do_read(8'h04, 0, 0, got_d, got_r);
    check("post_reset_reg1", got_d, '0);
    do_read(8'h08, 0, 0, got_d, got_r);
    check("post_reset_sum", got_d, '0);

    repeat (3) step();
    check("b_queue_drained", DW'(exp_bresp_q.size()), '0);
    check("r_queue_drained", DW'(exp_rdata_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach end, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
